if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter IQ_DEPTH, default 4, instruction queue entries; power of two, at least 2.
REQ-002 Parameter MAX_OUT, default 2, maximum in-flight fetch requests; at least 1, at most IQ_DEPTH.
REQ-003 Parameter RESET_PC, default 32'hbfc00000, first fetch address after reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 inst_sram_req  output  1  fetch request valid.
REQ-007 inst_sram_wr / inst_sram_size / inst_sram_wstrb / inst_sram_wdata  output  1/2/4/32  constant 0 / 2'h2 / 4'h0 / 32'h0.
REQ-008 inst_sram_addr  output  32  fetch address, equal to fetch_pc.
REQ-009 inst_sram_addr_ok  input  1  request accepted this cycle when inst_sram_req is also high.
REQ-010 inst_sram_data_ok / inst_sram_rdata  input  1/32  in-order response and instruction word.
REQ-011 redirect_valid / redirect_pc  input  1/32  one-cycle redirect (branch or exception) and its target.
REQ-012 ds_allowin  input  1  decode accepts an instruction.
REQ-013 fs_to_ds_valid  output  1  queue head valid.
REQ-014 fs_to_ds_bus  output  97  {badvaddr[96:65], adel[64], inst[63:32], pc[31:0]} of queue head.

Function
REQ-015 State: fetch_pc, outstanding counter (0..MAX_OUT), discard counter (0..MAX_OUT), PC tag FIFO of depth MAX_OUT, instruction queue of depth IQ_DEPTH, halt flag.
REQ-016 inst_sram_req SHALL be combinational: high iff !reset, !halt, !redirect_valid, fetch_pc[1:0]==0, outstanding<MAX_OUT, and (outstanding-discard)+queue_count<IQ_DEPTH.
REQ-017 Issue handshake is inst_sram_req && inst_sram_addr_ok: push fetch_pc into tag FIFO, outstanding+1, fetch_pc+=4 (32-bit wrap).
REQ-018 Response with discard>0: drop data, discard-1, pop tag, outstanding-1, no enqueue.
REQ-019 Response with discard==0: enqueue {32'h0, 0, rdata, popped tag}, outstanding-1; the credit rule guarantees the queue is never full at enqueue.
REQ-020 Issue and response in the same cycle: outstanding unchanged; tag FIFO push and pop both performed.
REQ-021 fs_to_ds_valid = queue_count!=0; dequeue on fs_to_ds_valid && ds_allowin; simultaneous enqueue and dequeue keeps queue_count unchanged; enqueue into an empty queue is visible the next cycle (one-cycle response-to-decode latency).
REQ-022 Misaligned fetch_pc with halt==0 and outstanding==discard: enqueue {fetch_pc, 1, 32'h0, fetch_pc} once queue space exists, then set halt; no request issued.
REQ-023 Redirect (takes priority over all else in its cycle): fetch_pc<=redirect_pc, queue cleared, halt cleared, discard<=outstanding-(inst_sram_data_ok?1:0); the same-cycle response is dropped.
REQ-024 Redirect with outstanding==0: discard stays 0; the first request at redirect_pc is issued the following cycle.
REQ-025 A back-to-back redirect while discard>0 SHALL recompute discard per REQ-023; no stale response ever reaches the queue.

Reset
REQ-026 On reset: fetch_pc=RESET_PC, outstanding=0, discard=0, queue and tag FIFO empty, halt=0, inst_sram_req=0, fs_to_ds_valid=0.
REQ-027 Reset mid-operation SHALL abandon in-flight requests without tracking; the environment resets the memory side in the same cycle.

Verification
REQ-028 Reset release, addr_ok always 1, data_ok 1 cycle later, ds_allowin=1 -> requests at bfc00000, bfc00004, ...; bus pc matches; steady rate of one per cycle.
REQ-029 ds_allowin=0 indefinitely -> exactly IQ_DEPTH (4) instructions queued, inst_sram_req low; 1 cycle after ds_allowin=1, fetch resumes.
REQ-030 Two requests in flight, redirect_valid to 80001000 -> both responses dropped, queue empty, the next accepted request address is 80001000, and the first delivered pc is 80001000.
REQ-031 Redirect to 80000002 -> no request; one entry {badvaddr=80000002, adel=1, inst=0}; req stays low until the next redirect.
REQ-032 Redirect in the same cycle as data_ok with outstanding=2 -> discard=1; the next response is dropped and the one after is delivered.
REQ-033 MAX_OUT=1, IQ_DEPTH=2 build, random addr_ok/data_ok delays -> in-order pcs, no overflow, no lost instructions.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: issues in-order fetch requests, tracks in-flight
// addresses, drops stale responses after redirects and buffers words for decode.
module if_fetch_queue #(
  parameter int unsigned IQ_DEPTH = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [96:0] fs_to_ds_bus
);

  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned AW = $clog2(IQ_DEPTH);
  localparam int unsigned QW = $clog2(IQ_DEPTH + 1);
  localparam int unsigned CW = $clog2(IQ_DEPTH + MAX_OUT + 1);

  typedef struct packed {
    logic [31:0] badvaddr;
    logic        adel;
    logic [31:0] inst;
    logic [31:0] pc;
  } iq_entry_t;

  logic [31:0]   fetch_pc;
  logic [OW-1:0] out_cnt;
  logic [OW-1:0] disc_cnt;
  logic          halt;
  logic [31:0]   tag_mem [MAX_OUT];
  logic [TW-1:0] tag_wp;
  logic [TW-1:0] tag_rp;
  iq_entry_t     iq_mem [IQ_DEPTH];
  logic [AW-1:0] iq_wp;
  logic [AW-1:0] iq_rp;
  logic [QW-1:0] iq_cnt;

  logic          misaligned;
  logic          issue;
  logic          resp;
  logic          resp_keep;
  logic          adel_enq;
  logic          enq;
  logic          deq;
  logic [CW-1:0] credit_used;
  iq_entry_t     enq_entry;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
  endfunction

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'h2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = fetch_pc;
  assign fs_to_ds_valid  = (iq_cnt != '0);
  assign fs_to_ds_bus    = iq_mem[iq_rp];

  // Credit counts words already owed to the queue so a response always finds room.
  always_comb begin
    credit_used   = CW'(out_cnt) - CW'(disc_cnt) + CW'(iq_cnt);
    misaligned    = (fetch_pc[1:0] != 2'b00);
    inst_sram_req = !reset && !halt && !redirect_valid && !misaligned &&
                    (out_cnt < OW'(MAX_OUT)) && (credit_used < CW'(IQ_DEPTH));
    issue         = inst_sram_req && inst_sram_addr_ok;
    resp          = inst_sram_data_ok;
    resp_keep     = resp && (disc_cnt == '0) && !redirect_valid;
    adel_enq      = !redirect_valid && !halt && misaligned &&
                    (out_cnt == disc_cnt) && (iq_cnt < QW'(IQ_DEPTH));
    enq           = resp_keep || adel_enq;
    deq           = fs_to_ds_valid && ds_allowin && !redirect_valid;
  end

  always_comb begin
    enq_entry = '0;
    if (adel_enq) begin
      enq_entry.badvaddr = fetch_pc;
      enq_entry.adel     = 1'b1;
      enq_entry.pc       = fetch_pc;
    end else begin
      enq_entry.inst = inst_sram_rdata;
      enq_entry.pc   = tag_mem[tag_rp];
    end
  end

  // Control state; a redirect overrides every other update in its cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      out_cnt  <= '0;
      disc_cnt <= '0;
      halt     <= 1'b0;
      tag_wp   <= '0;
      tag_rp   <= '0;
      iq_wp    <= '0;
      iq_rp    <= '0;
      iq_cnt   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      halt     <= 1'b0;
      iq_wp    <= '0;
      iq_rp    <= '0;
      iq_cnt   <= '0;
      out_cnt  <= out_cnt - OW'(resp);
      disc_cnt <= out_cnt - OW'(resp);
      if (resp) tag_rp <= tag_next(tag_rp);
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        tag_wp   <= tag_next(tag_wp);
      end
      if (resp) begin
        tag_rp <= tag_next(tag_rp);
        if (disc_cnt != '0) disc_cnt <= disc_cnt - OW'(1);
      end
      out_cnt <= out_cnt + OW'(issue) - OW'(resp);
      if (adel_enq) halt <= 1'b1;
      if (enq) iq_wp <= iq_wp + AW'(1);
      if (deq) iq_rp <= iq_rp + AW'(1);
      iq_cnt <= iq_cnt + QW'(enq) - QW'(deq);
    end
  end

  // Storage arrays carry no reset; their pointers define validity.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wp] <= fetch_pc;
    if (enq)   iq_mem[iq_wp]   <= enq_entry;
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue plus a randomized run on a minimal build.
module tb_if_fetch_queue;

  logic        clk;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [96:0] fs_to_ds_bus;

  logic        s_reset, s_req, s_wr, s_addr_ok, s_data_ok, s_redirect, s_allowin, s_valid;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata, s_rdata, s_redirect_pc;
  logic [96:0] s_bus;

  if_fetch_queue dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ds_allowin(ds_allowin), .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus)
  );

  if_fetch_queue #(.IQ_DEPTH(2), .MAX_OUT(1)) dut_small (
    .clk(clk), .reset(s_reset),
    .inst_sram_req(s_req), .inst_sram_wr(s_wr),
    .inst_sram_size(s_size), .inst_sram_wstrb(s_wstrb),
    .inst_sram_addr(s_addr), .inst_sram_wdata(s_wdata),
    .inst_sram_addr_ok(s_addr_ok), .inst_sram_data_ok(s_data_ok),
    .inst_sram_rdata(s_rdata),
    .redirect_valid(s_redirect), .redirect_pc(s_redirect_pc),
    .ds_allowin(s_allowin), .fs_to_ds_valid(s_valid), .fs_to_ds_bus(s_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } pend_t;

  pend_t       pend[$];
  pend_t       s_pend[$];
  logic [31:0] acc_q[$];
  logic [96:0] del_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          lat = 1;
  logic        cyc_req;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // One clock of the main DUT with an in-order memory of fixed latency.
  task automatic tick();
    inst_sram_addr_ok = 1'b1;
    if (pend.size() != 0 && pend[0].ready <= cyc) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = ~pend[0].addr;
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
    end
    #1;
    cyc_req = inst_sram_req;
    if (inst_sram_data_ok) void'(pend.pop_front());
    if (inst_sram_req && inst_sram_addr_ok) begin
      acc_q.push_back(inst_sram_addr);
      pend.push_back('{inst_sram_addr, cyc + lat});
    end
    if (fs_to_ds_valid && ds_allowin) del_q.push_back(fs_to_ds_bus);
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    pend.delete();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    acc_q.delete();
    del_q.delete();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    acc_q.delete();
    del_q.delete();
  endtask

  function automatic logic [96:0] del_at(input int i);
    if (i < del_q.size()) return del_q[i];
    return {32'hdeadbeef, 1'b1, 32'hdeadbeef, 32'hdeadbeef};
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_q.size()) return acc_q[i];
    return 32'hdeadbeef;
  endfunction

  logic [96:0] e;
  logic [31:0] s_exp_pc;
  int          s_acc, s_del;
  bit          draining;

  // One clock of the small DUT with random handshakes and latencies.
  task automatic tick_small();
    s_addr_ok = draining ? 1'b0 : 1'($urandom_range(0, 1));
    s_allowin = draining ? 1'b1 : 1'($urandom_range(0, 1));
    if (s_pend.size() != 0 && s_pend[0].ready <= cyc) begin
      s_data_ok = 1'b1;
      s_rdata   = ~s_pend[0].addr;
    end else begin
      s_data_ok = 1'b0;
      s_rdata   = 32'h0;
    end
    #1;
    if (s_data_ok) void'(s_pend.pop_front());
    if (s_req && s_addr_ok) begin
      s_pend.push_back('{s_addr, cyc + int'($urandom_range(1, 4))});
      s_acc++;
    end
    check("small_outstanding_le1", 32'(s_pend.size() > 1), 32'h0);
    if (s_valid && s_allowin) begin
      check("small_pc", s_bus[31:0], s_exp_pc);
      check("small_inst", s_bus[63:32], ~s_exp_pc);
      s_exp_pc = s_exp_pc + 32'd4;
      s_del++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; ds_allowin = 1'b1;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    s_reset = 1'b1; s_redirect = 1'b0; s_redirect_pc = 32'h0; s_allowin = 1'b0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;
    draining = 1'b0;

    // Reset values and constant write-side outputs.
    tick();
    check("rst_req", 32'(inst_sram_req), 32'h0);
    check("rst_valid", 32'(fs_to_ds_valid), 32'h0);
    check("rst_addr", inst_sram_addr, 32'hbfc00000);
    check("const_wr", 32'(inst_sram_wr), 32'h0);
    check("const_size", 32'(inst_sram_size), 32'h2);
    check("const_wstrb", 32'(inst_sram_wstrb), 32'h0);
    check("const_wdata", inst_sram_wdata, 32'h0);

    // Streaming at one fetch per cycle.
    lat = 1;
    do_reset();
    ticks(12);
    check("stream_acc_cnt", 32'(acc_q.size()), 32'd12);
    check("stream_del_cnt", 32'(del_q.size()), 32'd10);
    check("stream_acc0", acc_at(0), 32'hbfc00000);
    check("stream_acc1", acc_at(1), 32'hbfc00004);
    check("stream_acc11", acc_at(11), 32'hbfc0002c);
    e = del_at(0);
    check("stream_pc0", e[31:0], 32'hbfc00000);
    check("stream_inst0", e[63:32], 32'h403fffff);
    check("stream_adel0", 32'(e[64]), 32'h0);
    check("stream_bad0", e[96:65], 32'h0);
    e = del_at(9);
    check("stream_pc9", e[31:0], 32'hbfc00024);

    // Decode stall fills the queue, then resumes one cycle after release.
    do_reset();
    ds_allowin = 1'b0;
    ticks(10);
    check("stall_acc_cnt", 32'(acc_q.size()), 32'd4);
    check("stall_del_cnt", 32'(del_q.size()), 32'd0);
    check("stall_req", 32'(cyc_req), 32'h0);
    check("stall_valid", 32'(fs_to_ds_valid), 32'h1);
    ds_allowin = 1'b1;
    tick();
    check("resume_req_first", 32'(cyc_req), 32'h0);
    tick();
    check("resume_req_next", 32'(cyc_req), 32'h1);
    check("resume_acc4", acc_at(4), 32'hbfc00010);
    ticks(8);
    e = del_at(3);
    check("resume_pc3", e[31:0], 32'hbfc0000c);
    e = del_at(4);
    check("resume_pc4", e[31:0], 32'hbfc00010);

    // Redirect with two requests in flight.
    lat = 3;
    do_reset();
    ticks(2);
    check("redir_acc_cnt", 32'(acc_q.size()), 32'd2);
    do_redirect(32'h80001000);
    check("redir_valid", 32'(fs_to_ds_valid), 32'h0);
    ticks(10);
    check("redir_acc0", acc_at(0), 32'h80001000);
    e = del_at(0);
    check("redir_pc0", e[31:0], 32'h80001000);
    check("redir_inst0", e[63:32], 32'h7fffefff);
    e = del_at(1);
    check("redir_pc1", e[31:0], 32'h80001004);

    // Misaligned redirect target raises one address-error entry and halts.
    do_redirect(32'h80000002);
    ticks(10);
    check("adel_acc_cnt", 32'(acc_q.size()), 32'd0);
    check("adel_del_cnt", 32'(del_q.size()), 32'd1);
    e = del_at(0);
    check("adel_bad", e[96:65], 32'h80000002);
    check("adel_flag", 32'(e[64]), 32'h1);
    check("adel_inst", e[63:32], 32'h0);
    check("adel_pc", e[31:0], 32'h80000002);
    check("adel_req", 32'(cyc_req), 32'h0);

    // Redirect from an idle, halted state issues on the next cycle.
    do_redirect(32'h80002000);
    tick();
    check("idle_redir_req", 32'(cyc_req), 32'h1);
    check("idle_redir_acc0", acc_at(0), 32'h80002000);
    ticks(6);
    e = del_at(0);
    check("idle_redir_pc0", e[31:0], 32'h80002000);

    // Redirect coinciding with a response: only one more response is dropped.
    lat = 2;
    do_reset();
    ticks(2);
    do_redirect(32'h80003000);
    ticks(8);
    check("sameresp_acc0", acc_at(0), 32'h80003000);
    e = del_at(0);
    check("sameresp_pc0", e[31:0], 32'h80003000);
    check("sameresp_inst0", e[63:32], 32'h7fffcfff);

    // Back-to-back redirects: only the last target is ever delivered.
    lat = 3;
    do_reset();
    ticks(2);
    do_redirect(32'h80004000);
    do_redirect(32'h80005000);
    ticks(10);
    check("b2b_acc0", acc_at(0), 32'h80005000);
    e = del_at(0);
    check("b2b_pc0", e[31:0], 32'h80005000);
    e = del_at(1);
    check("b2b_pc1", e[31:0], 32'h80005004);

    // Minimal build under random handshakes, then a full drain.
    check("small_wr", 32'(s_wr), 32'h0);
    check("small_size", 32'(s_size), 32'h2);
    check("small_wstrb", 32'(s_wstrb), 32'h0);
    check("small_wdata", s_wdata, 32'h0);
    @(posedge clk);
    #1;
    s_reset = 1'b0;
    s_exp_pc = 32'hbfc00000;
    s_acc = 0;
    s_del = 0;
    for (int i = 0; i < 300; i++) tick_small();
    draining = 1'b1;
    for (int i = 0; i < 15; i++) tick_small();
    check("small_progress", 32'(s_del >= 20), 32'h1);
    check("small_no_loss", 32'(s_del), 32'(s_acc));
    check("small_drained_valid", 32'(s_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
